// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core memory-stage blocks.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Number of low address bits that must be zero for a word access.
    localparam int unsigned ALIGN_W = 2;

endpackage

// File: rtl/dmem_ctrl.sv
// M-stage data-memory responder: bridges pipeline loads/stores to a slow
// backing memory over req/ready, stalling the pipeline while outstanding.
module dmem_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memreadM,
    input  logic          memwriteM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    output logic [DW-1:0] readdataM,
    output logic          stallM,
    output logic          bus_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    dmem_state_t              state;
    logic [CW-1:0]            cnt;
    logic [AW-1:ALIGN_W]      addrReg;
    logic [DW-1:0]            wdataReg;
    logic [DW-1:0]            rdataReg;
    logic                     weReg;
    logic                     req;
    logic                     aligned;

    assign req     = memreadM | memwriteM;
    assign aligned = (aluoutM[ALIGN_W-1:0] == ALIGN_W'(0));

    // Stall is gated by reset so the pipeline is released the moment reset lands.
    assign stallM    = reset & (((state == IDLE) & req & aligned) | (state == REQ));
    assign mem_req   = (state == REQ);
    assign mem_we    = (state == REQ) & weReg;
    assign mem_addr  = {addrReg, ALIGN_W'(0)};
    assign mem_wdata = wdataReg;
    assign readdataM = (state == DONE) ? rdataReg : DW'(0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addrReg  <= '0;
            wdataReg <= '0;
            rdataReg <= '0;
            weReg    <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (aligned) begin
                            addrReg  <= aluoutM[AW-1:ALIGN_W];
                            wdataReg <= writedataM;
                            weReg    <= memwriteM;
                            cnt      <= '0;
                            state    <= REQ;
                        end
                        // Misaligned, or conflicting read+write (serviced as a write).
                        if (!aligned || (memreadM && memwriteM)) begin
                            bus_err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        rdataReg <= weReg ? DW'(0) : mem_rdata;
                        state    <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        bus_err  <= 1'b1;
                        rdataReg <= '0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed-vector bench for dmem_ctrl with a programmable-latency memory.
module tb_dmem_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          memreadM;
    logic          memwriteM;
    logic [AW-1:0] aluoutM;
    logic [DW-1:0] writedataM;
    logic [DW-1:0] readdataM;
    logic          stallM;
    logic          bus_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    int nVec = 0;
    int nErr = 0;

    dmem_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access from IDLE, play memory with ready on REQ cycle readyAt
    // (0 = never), and check the DONE-cycle results.
    task automatic runAccess(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int readyAt, input logic [31:0] rdata,
                             input int expStall, input logic [31:0] expRd,
                             input logic expErr);
        int   stalls   = 0;
        int   reqCyc   = 0;
        int   reqEdges = 0;
        int   guard    = 0;
        logic prevReq  = 1'b0;
        logic done     = 1'b0;
        memreadM   = rd;
        memwriteM  = wr;
        aluoutM    = addr;
        writedataM = wdata;
        while (!done && guard < 40) begin
            #1;
            if (mem_req && !prevReq) reqEdges++;
            prevReq = mem_req;
            if (mem_req) begin
                reqCyc++;
                chk({tag, "_addr"}, mem_addr, addr);
                chk({tag, "_we"}, 32'(mem_we), 32'(wr));
                if (wr) chk({tag, "_wdata"}, mem_wdata, wdata);
                mem_ready = (reqCyc == readyAt);
                mem_rdata = rdata;
            end else begin
                mem_ready = 1'b0;
            end
            if (stallM) begin
                stalls++;
            end else if (stalls > 0) begin
                done = 1'b1;
                chk({tag, "_rdata"}, readdataM, expRd);
                chk({tag, "_err"}, 32'(bus_err), 32'(expErr));
                chk({tag, "_stalls"}, 32'(stalls), 32'(expStall));
                chk({tag, "_reqs"}, 32'(reqEdges), 32'd1);
            end
            if (!done) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        tick();
        memreadM  = 1'b0;
        memwriteM = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        memreadM   = 1'b0;
        memwriteM  = 1'b0;
        aluoutM    = '0;
        writedataM = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        #12;
        chk("rst_stall", 32'(stallM), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_rdata", readdataM, 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        reset = 1'b1;
        tick();

        runAccess("load", 1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF, 2, 32'hDEADBEEF, 1'b0);
        runAccess("store", 1'b0, 1'b1, 32'h80, 32'h12345678, 3, 32'hFFFFFFFF, 4, 32'h0, 1'b0);
        runAccess("ready_at_to", 1'b1, 1'b0, 32'hC0, 32'h0, 4, 32'hCAFEF00D, 5, 32'hCAFEF00D, 1'b0);
        // Back-to-back: second access issued in the IDLE cycle right after DONE.
        runAccess("b2b_ld", 1'b1, 1'b0, 32'h100, 32'h0, 2, 32'h0BADF00D, 3, 32'h0BADF00D, 1'b0);
        runAccess("b2b_st", 1'b0, 1'b1, 32'h104, 32'hA5A5A5A5, 1, 32'h0, 2, 32'h0, 1'b0);
        runAccess("timeout", 1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h11111111, 5, 32'h0, 1'b1);

        // Reset mid-REQ: outputs must fall with no clock edge.
        memreadM = 1'b1;
        aluoutM  = 32'h300;
        tick();
        chk("midrst_inreq", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_stall", 32'(stallM), 32'd0);
        chk("midrst_err", 32'(bus_err), 32'd0);
        memreadM = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        runAccess("post_rst", 1'b1, 1'b0, 32'h44, 32'h0, 1, 32'h76543210, 2, 32'h76543210, 1'b0);

        // Misaligned load: no request, no stall, sticky error.
        memreadM = 1'b1;
        aluoutM  = 32'h41;
        #1;
        chk("mis_stall", 32'(stallM), 32'd0);
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_rdata", readdataM, 32'd0);
        chk("mis_err_pre", 32'(bus_err), 32'd0);
        tick();
        chk("mis_err", 32'(bus_err), 32'd1);
        chk("mis_req2", 32'(mem_req), 32'd0);
        memreadM = 1'b0;
        tick();
        runAccess("sticky", 1'b1, 1'b0, 32'h48, 32'h0, 1, 32'h00C0FFEE, 2, 32'h00C0FFEE, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
